// File: rtl/alu_serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B, one bit per clock, LSB first.
// Start/done handshake. Borrow, Zero and signed-Overflow flags are registered
// alongside Diff and hold until the next completion.
module alu_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Zero,
    output logic             Overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0] b_q, b_d;        // subtrahend, shifted right each RUN cycle
    logic [WIDTH-1:0] res_q, res_d;    // result bits enter at the MSB side
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;    // borrow carried between bit positions
    logic             a_msb_q, a_msb_d; // operand sign bits kept for Overflow,
    logic             b_msb_q, b_msb_d; // since the shift registers lose them
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // One full-subtractor bit slice on the current LSBs.
    logic             d_bit;
    logic             bout;
    logic [WIDTH-1:0] res_shift;

    assign d_bit     = a_q[0] ^ b_q[0] ^ bin_q;
    assign bout      = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    assign res_shift = {d_bit, res_q[WIDTH-1:1]};

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state, bit-serial step and result capture on the final RUN edge.
    always_comb begin
        // NOTE: every target gets a hold default first so no latch is inferred.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = A;
                    b_d     = B;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d = res_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = bout;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    diff_d   = res_shift;
                    borrow_d = bout;
                    zero_d   = (res_shift == '0);
                    ovf_d    = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign Diff     = diff_q;
    assign Borrow   = borrow_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_subtractor.sv
// Self-checking bench for alu_serial_subtractor (WIDTH = 8): directed vector
// table, mid-RUN start glitch, back-to-back accept, reset abort, random sweep.
module tb_alu_serial_subtractor;

    localparam int W       = 8;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         busy, done;
    logic [W-1:0] Diff;
    logic         Borrow, Zero, Overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Diff     (Diff),
        .Borrow   (Borrow),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // done must never be high on two consecutive cycles.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done && prev_done) begin
            total_cnt++;
            $display("FAIL done_consecutive: got 1 expected 0");
        end
        prev_done = done;
    end

    // Reference model: width-exact subtraction with flags.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t         v;
        logic [W:0]   wide;
        wide     = {1'b0, a} - {1'b0, b};
        v.a      = a;
        v.b      = b;
        v.diff   = wide[W-1:0];
        v.borrow = wide[W];
        v.zero   = (wide[W-1:0] == '0);
        v.ovf    = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
        return v;
    endfunction

    // Accept one operation and wait for done; k = edges from accept to done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch,
                         output int k, output int busy_n);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        busy_n = 0;
        while (!done && k < TIMEOUT) begin
            if (busy) busy_n++;
            if (k == glitch) begin
                A = ~a; B = ~b; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'(k), 32'(W));
    endtask

    task automatic check_result(input string tag, input vec_t e);
        check({tag, "_diff"},   32'(Diff),     32'(e.diff));
        check({tag, "_borrow"}, 32'(Borrow),   32'(e.borrow));
        check({tag, "_zero"},   32'(Zero),     32'(e.zero));
        check({tag, "_ovf"},    32'(Overflow), 32'(e.ovf));
    endtask

    vec_t vecs[9];
    int   k, busy_n, done_seen;
    vec_t e;

    initial begin
        //          a     b     diff  brw   zero  ovf
        vecs[0] = '{8'd81,  8'd135, 8'd202, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'd197, 8'd0,   8'd197, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'd126, 8'd126, 8'd0,   1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'd231, 8'd119, 8'd112, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'd0,   8'd1,   8'd255, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'd128, 8'd1,   8'd127, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'd127, 8'd255, 8'd128, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'd255, 8'd255, 8'd0,   1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(Diff), 0);
        check("rst_flags", {29'd0, Borrow, Zero, Overflow}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed table: latency, busy length, results, single-cycle done.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, -1, k, busy_n);
            check($sformatf("v%0d_latency", i), 32'(k), 32'(W));
            check($sformatf("v%0d_busy", i), 32'(busy_n), 32'(W));
            check_result($sformatf("v%0d", i), vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_done_drop", i), 32'(done), 0);
            check($sformatf("v%0d_hold", i), 32'(Diff), 32'(vecs[i].diff));
        end

        // Start pulse and operand change during RUN are ignored.
        do_op(8'd231, 8'd119, 3, k, busy_n);
        check("glitch_latency", 32'(k), 32'(W));
        check_result("glitch", vecs[3]);

        // Back-to-back: start held through RUN and DONE.
        @(negedge clk);
        A = 8'd11; B = 8'd14; start = 1'b1;
        @(negedge clk);
        A = 8'd70; B = 8'd83;
        k = 0;
        while (!done && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_latency", 32'(k), 32'(W));
        check_result("b2b_first", '{8'd11, 8'd14, 8'd253, 1'b1, 1'b0, 1'b0});
        k = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end while (!done && k < TIMEOUT);
        check("b2b_spacing", 32'(k), 32'(W + 1));
        check_result("b2b_second", '{8'd70, 8'd83, 8'd243, 1'b1, 1'b0, 1'b0});

        // Reset in RUN cycle 4 aborts; outputs clear immediately, no done follows.
        @(negedge clk);
        A = 8'd195; B = 8'd138; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_diff", 32'(Diff), 0);
        check("abort_flags", {29'd0, Borrow, Zero, Overflow}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 0);
        // Both operands negative: -61 - (-118) = 57 fits, so no overflow.
        do_op(8'd195, 8'd138, -1, k, busy_n);
        check("rerun_latency", 32'(k), 32'(W));
        check_result("rerun", '{8'd195, 8'd138, 8'd57, 1'b0, 1'b0, 1'b0});

        // Random sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            e  = model(ra, rb);
            do_op(ra, rb, -1, k, busy_n);
            check($sformatf("rnd%0d_diff", i), 32'(Diff), 32'(e.diff));
            check($sformatf("rnd%0d_flags", i), {29'd0, Borrow, Zero, Overflow},
                  {29'd0, e.borrow, e.zero, e.ovf});
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
